// File: rtl/image_three2window_pkg.sv
// Shared constants, FSM encoding and helpers for the three-row window builder.
package image_three2window_pkg;

  localparam int W           = 8;
  localparam int ADDR_BITS   = 10;
  localparam int RD_LATENCY  = 2;
  localparam int CFIFO_DEPTH = 4;
  localparam int COL_W       = 3 * W;
  localparam int WIN_W       = 9 * W;
  localparam int CNT_BITS    = $clog2(CFIFO_DEPTH + 1);

  // One-hot, matching the row buffer's state style.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } state_e;

  // Number of reads currently travelling through the row buffer pipeline.
  function automatic int count_ones(input logic [RD_LATENCY-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      n = n + (v[i] ? 1 : 0);
    end
    return n;
  endfunction

endpackage

// File: rtl/image_three2window_if.sv
// Row-buffer read side plus window stream towards the convolution engine.
interface image_three2window_if;
  import image_three2window_pkg::*;

  logic                 Start_Row;
  logic [ADDR_BITS-1:0] Row_Num_After_Padding;
  logic [ADDR_BITS-1:0] Rd_Addr;
  logic [COL_W-1:0]     Row_Data;
  logic                 Busy;
  logic [WIN_W-1:0]     M_Window;
  logic                 M_Valid;
  logic                 M_Ready;
  logic                 Row_Done;

  // Window builder side.
  modport master (
    input  Start_Row, Row_Num_After_Padding, Row_Data, M_Ready,
    output Rd_Addr, Busy, M_Window, M_Valid, Row_Done
  );

  // Row buffer / convolution engine side.
  modport slave (
    output Start_Row, Row_Num_After_Padding, Row_Data, M_Ready,
    input  Rd_Addr, Busy, M_Window, M_Valid, Row_Done
  );

endinterface

// File: rtl/image_window_col_fifo.sv
// Show-ahead synchronous FIFO holding 3-row column words between the row
// buffer read pipeline and the window shift register.
module image_window_col_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q;
  logic [PTR_BITS-1:0] rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                rd_s;

  function automatic logic [PTR_BITS-1:0] ptr_next(input logic [PTR_BITS-1:0] p);
    if (p == PTR_BITS'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_BITS'(1);
    end
  endfunction

  assign rd_s      = rd_en_i && (count_q != '0);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);

  // Storage, pointers and occupancy; the producer guarantees it never overfills.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (rd_s) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({wr_en_i, rd_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/image_three2window.sv
// Reads one padded 3-row band column by column and streams 3x3 windows
// under valid/ready flow control.
module image_three2window
  import image_three2window_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  image_three2window_if.master bus
);

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  n_q, n_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [ADDR_BITS-1:0]  col_cnt_q, col_cnt_d;
  logic [RD_LATENCY-1:0] vld_q;
  logic [COL_W-1:0]      col_q [3];
  logic                  m_valid_q, m_valid_d;
  logic                  busy_q;
  logic                  row_done_q;

  logic                  issue_s;
  logic                  start_s;
  logic                  pop_s;
  logic                  credit_s;
  int                    inflight_s;
  logic                  fifo_empty_s;
  logic [CNT_BITS-1:0]   fifo_count_s;
  logic [COL_W-1:0]      fifo_data_s;
  logic [WIN_W-1:0]      win_s;

  image_window_col_fifo #(
    .WIDTH (COL_W),
    .DEPTH (CFIFO_DEPTH)
  ) u_col_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (vld_q[RD_LATENCY-1]),
    .wr_data_i (bus.Row_Data),
    .rd_en_i   (pop_s),
    .rd_data_o (fifo_data_s),
    .count_o   (fifo_count_s),
    .empty_o   (fifo_empty_s)
  );

  // A read may only be issued if its data is sure to find a FIFO slot.
  always_comb begin
    inflight_s = count_ones(vld_q);
    credit_s   = ((int'(fifo_count_s) + inflight_s) < CFIFO_DEPTH);
  end

  // Row sequencing: latch N, issue addresses under credit, drain, retire.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    issue_s = 1'b0;
    start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start_Row) begin
          state_d = ST_ISSUE;
          n_d     = bus.Row_Num_After_Padding;
          addr_d  = '0;
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (addr_q >= n_q) begin
          state_d = ST_DRAIN;
        end else if (credit_s) begin
          issue_s = 1'b1;
          addr_d  = addr_q + ADDR_BITS'(1);
          if (addr_d == n_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if ((inflight_s == 0) && fifo_empty_s && (!m_valid_q || bus.M_Ready)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // Window shift control: pop whenever the output slot is free or being emptied.
  always_comb begin
    pop_s     = !fifo_empty_s && (!m_valid_q || bus.M_Ready);
    col_cnt_d = col_cnt_q;
    m_valid_d = m_valid_q;
    if (start_s) begin
      col_cnt_d = '0;
      m_valid_d = 1'b0;
    end else if (pop_s) begin
      col_cnt_d = col_cnt_q + ADDR_BITS'(1);
      m_valid_d = (col_cnt_d >= ADDR_BITS'(3));
    end else if (bus.M_Ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // State, counters, read-tag pipe, shift window and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      addr_q     <= '0;
      col_cnt_q  <= '0;
      vld_q      <= '0;
      m_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      row_done_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        col_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      col_cnt_q  <= col_cnt_d;
      vld_q      <= RD_LATENCY'({vld_q, issue_s});
      m_valid_q  <= m_valid_d;
      busy_q     <= (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
      row_done_q <= (state_d == ST_DONE);
      if (pop_s) begin
        col_q[0] <= col_q[1];
        col_q[1] <= col_q[2];
        col_q[2] <= fifo_data_s;
      end
    end
  end

  // Element k = row*3 + col; column words carry top row in their low byte.
  always_comb begin
    win_s = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_s[(r*3 + c)*W +: W] = col_q[c][r*W +: W];
      end
    end
  end

  assign bus.Rd_Addr  = addr_q;
  assign bus.Busy     = busy_q;
  assign bus.M_Valid  = m_valid_q;
  assign bus.M_Window = win_s;
  assign bus.Row_Done = row_done_q;

endmodule

// File: tb/tb_image_three2window.sv
// Scoreboard bench for image_three2window with a 2-cycle row buffer model.
module tb_image_three2window;
  import image_three2window_pkg::*;

  logic clk = 1'b0;
  logic rst;

  image_three2window_if ifc();

  image_three2window dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Row buffer model: column word appears two cycles after its address.
  logic [ADDR_BITS-1:0] a1_q, a2_q;
  logic [7:0]           base;
  logic [7:0]           pix_s;
  always @(posedge clk) begin
    a1_q <= ifc.Rd_Addr;
    a2_q <= a1_q;
  end
  always_comb begin
    pix_s        = a2_q[7:0] + base;
    ifc.Row_Data = {pix_s + 8'h20, pix_s + 8'h10, pix_s};
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIN_W-1:0] exp_q[$];
  logic [WIN_W-1:0] win_hist[$];
  int win_cnt = 0, done_cnt = 0, valid_cnt = 0, busy_cnt = 0;
  bit saw_pause = 1'b0;
  int cur_n = 0;

  function automatic logic [WIN_W-1:0] exp_win(input int j, input logic [7:0] b);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[(r*3 + c)*8 +: 8] = 8'(r*16 + j + c) + b;
      end
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and stall-stability observer, sampled on the falling edge.
  task automatic monitor();
    logic [WIN_W-1:0] e, stall_win;
    bit stall_prev, prev_busy;
    logic [ADDR_BITS-1:0] prev_addr;
    stall_prev = 1'b0;
    prev_busy  = 1'b0;
    prev_addr  = '0;
    stall_win  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
        prev_busy  = 1'b0;
      end else begin
        if (stall_prev) begin
          n_checks++;
          if (ifc.M_Valid !== 1'b1 || ifc.M_Window !== stall_win) begin
            n_fail++;
            $display("FAIL stall_hold: valid=%b window=%h required valid=1 window=%h",
                     ifc.M_Valid, ifc.M_Window, stall_win);
          end
        end
        if (ifc.M_Valid === 1'b1 && ifc.M_Ready === 1'b1) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra: window %h accepted, required none", ifc.M_Window);
          end else begin
            e = exp_q.pop_front();
            if (ifc.M_Window !== e) begin
              n_fail++;
              $display("FAIL sb_window: got %h required %h", ifc.M_Window, e);
            end
          end
          win_hist.push_back(ifc.M_Window);
          win_cnt++;
        end
        if (ifc.Busy && prev_busy && ifc.Rd_Addr == prev_addr && int'(ifc.Rd_Addr) < cur_n)
          saw_pause = 1'b1;
        if (ifc.Row_Done === 1'b1) done_cnt++;
        if (ifc.M_Valid === 1'b1) valid_cnt++;
        if (ifc.Busy === 1'b1) busy_cnt++;
        stall_prev = (ifc.M_Valid === 1'b1) && (ifc.M_Ready === 1'b0);
        stall_win  = ifc.M_Window;
        prev_busy  = ifc.Busy;
        prev_addr  = ifc.Rd_Addr;
      end
    end
  endtask

  task automatic start_row(input int n, input logic [7:0] b);
    cur_n = n;
    base  = b;
    for (int j = 0; j < n - 2; j++) exp_q.push_back(exp_win(j, b));
    ifc.Row_Num_After_Padding = ADDR_BITS'(n);
    ifc.Start_Row = 1'b1;
    tick();
    ifc.Start_Row = 1'b0;
  endtask

  // Waits for Row_Done (optionally toggling M_Ready), then moves into IDLE.
  task automatic wait_done(input int budget, input bit toggle, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      cycles++;
      if (toggle) ifc.M_Ready = ~ifc.M_Ready;
      if (ifc.Row_Done === 1'b1) ok = 1'b1;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++; if (ifc.Rd_Addr !== '0) begin n_fail++; $display("FAIL rst_rd_addr: got %h required 0", ifc.Rd_Addr); end
    n_checks++; if (ifc.Busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", ifc.Busy); end
    n_checks++; if (ifc.M_Valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", ifc.M_Valid); end
    n_checks++; if (ifc.M_Window !== '0) begin n_fail++; $display("FAIL rst_window: got %h required 0", ifc.M_Window); end
    n_checks++; if (ifc.Row_Done !== 1'b0) begin n_fail++; $display("FAIL rst_row_done: got %b required 0", ifc.Row_Done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int w0, d0, b0, cyc;
    bit ok;
    w0 = win_cnt; d0 = done_cnt; b0 = busy_cnt; saw_pause = 1'b0;
    ifc.M_Ready = 1'b1;
    start_row(5, 8'h00);
    wait_done(200, 1'b0, ok, cyc);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: Row_Done not seen, required within 200 cycles"); end
    n_checks++; if (win_cnt - w0 != 3) begin n_fail++; $display("FAIL basic_count: got %0d windows required 3", win_cnt - w0); end
    n_checks++; if (win_cnt > w0 && win_hist[w0] !== 72'h222120121110020100) begin
      n_fail++; $display("FAIL basic_win0: got %h required 222120121110020100", win_hist[w0]); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses required 1", done_cnt - d0); end
    n_checks++; if (busy_cnt - b0 != cyc) begin n_fail++; $display("FAIL basic_busy_span: busy %0d cycles required %0d", busy_cnt - b0, cyc); end
    n_checks++; if (ifc.Busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b required 0", ifc.Busy); end
    n_checks++; if (saw_pause) begin n_fail++; $display("FAIL basic_no_pause: got pause required none"); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_sb_left: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    int w0, d0, cyc;
    bit ok;
    w0 = win_cnt; d0 = done_cnt;
    ifc.M_Ready = 1'b1;
    start_row(8, 8'h08);
    wait_done(300, 1'b1, ok, cyc);
    ifc.M_Ready = 1'b1;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: Row_Done not seen, required within 300 cycles"); end
    n_checks++; if (win_cnt - w0 != 6) begin n_fail++; $display("FAIL stall_count: got %0d windows required 6", win_cnt - w0); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL stall_done: got %0d pulses required 1", done_cnt - d0); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_sb_left: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_short_row();
    int v0, d0, cyc;
    bit ok;
    v0 = valid_cnt; d0 = done_cnt;
    start_row(2, 8'h11);
    wait_done(100, 1'b0, ok, cyc);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL short_timeout: Row_Done not seen, required within 100 cycles"); end
    n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL short_valid: got %0d valid cycles required 0", valid_cnt - v0); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL short_done: got %0d pulses required 1", done_cnt - d0); end
    n_checks++; if (ifc.Busy !== 1'b0) begin n_fail++; $display("FAIL short_busy: got %b required 0", ifc.Busy); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL short_sb_left: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_ignore_start();
    int w0, d0, cyc;
    bit ok;
    w0 = win_cnt; d0 = done_cnt;
    start_row(6, 8'h40);
    tick();
    ifc.Row_Num_After_Padding = ADDR_BITS'(3);
    ifc.Start_Row = 1'b1;
    tick();
    ifc.Start_Row = 1'b0;
    wait_done(200, 1'b0, ok, cyc);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ignore_timeout: Row_Done not seen, required within 200 cycles"); end
    n_checks++; if (win_cnt - w0 != 4) begin n_fail++; $display("FAIL ignore_count: got %0d windows required 4", win_cnt - w0); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL ignore_done: got %0d pulses required 1", done_cnt - d0); end
    repeat (20) tick();
    n_checks++; if (ifc.Busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy: got %b required 0 (second start taken)", ifc.Busy); end
  endtask

  task automatic test_reset_mid_row();
    int w0, d0, cyc;
    bit ok;
    w0 = win_cnt; saw_pause = 1'b0;
    ifc.M_Ready = 1'b0;
    start_row(16, 8'h30);
    repeat (15) tick();
    // With the output stalled: 3 columns sit in the window, CFIFO_DEPTH in the FIFO.
    n_checks++; if (!saw_pause) begin n_fail++; $display("FAIL credit_pause: got no pause required Rd_Addr to stall"); end
    n_checks++; if (ifc.Rd_Addr !== ADDR_BITS'(3 + CFIFO_DEPTH)) begin
      n_fail++; $display("FAIL credit_addr: got %0d required %0d", ifc.Rd_Addr, 3 + CFIFO_DEPTH); end
    ifc.M_Ready = 1'b1;
    for (int i = 0; i < 100 && win_cnt < w0 + 3; i++) tick();
    n_checks++; if (win_cnt < w0 + 3) begin n_fail++; $display("FAIL midrst_timeout: got %0d windows required 3", win_cnt - w0); end
    rst = 1'b1;
    exp_q.delete();
    tick();
    n_checks++; if (ifc.Rd_Addr !== '0) begin n_fail++; $display("FAIL midrst_rd_addr: got %h required 0", ifc.Rd_Addr); end
    n_checks++; if (ifc.Busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", ifc.Busy); end
    n_checks++; if (ifc.M_Valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b required 0", ifc.M_Valid); end
    n_checks++; if (ifc.M_Window !== '0) begin n_fail++; $display("FAIL midrst_window: got %h required 0", ifc.M_Window); end
    n_checks++; if (ifc.Row_Done !== 1'b0) begin n_fail++; $display("FAIL midrst_row_done: got %b required 0", ifc.Row_Done); end
    rst = 1'b0;
    tick();
    w0 = win_cnt; d0 = done_cnt;
    start_row(4, 8'h50);
    wait_done(100, 1'b0, ok, cyc);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL postrst_timeout: Row_Done not seen, required within 100 cycles"); end
    n_checks++; if (win_cnt - w0 != 2) begin n_fail++; $display("FAIL postrst_count: got %0d windows required 2", win_cnt - w0); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL postrst_done: got %0d pulses required 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int w0, cyc;
    bit ok;
    logic [7:0] bases [3];
    bases[0] = 8'h60; bases[1] = 8'h80; bases[2] = 8'hA0;
    ifc.M_Ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      w0 = win_cnt;
      start_row(6, bases[r]);
      wait_done(200, 1'b0, ok, cyc);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: row %0d Row_Done not seen", r); end
      n_checks++; if (win_cnt - w0 != 4) begin n_fail++; $display("FAIL b2b_count: row %0d got %0d windows required 4", r, win_cnt - w0); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_sb_left: row %0d got %0d pending required 0", r, exp_q.size()); end
    end
  endtask

  initial begin
    rst = 1'b1;
    base = 8'h00;
    ifc.Start_Row = 1'b0;
    ifc.Row_Num_After_Padding = '0;
    ifc.M_Ready = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_stall();
    test_short_row();
    test_ignore_start();
    test_reset_mid_row();
    test_back_to_back();
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/image_three2window.md
Name: image_three2window

Overview:
- Consumer end of the four-to-three row buffer interface.
- On each Start_Row pulse it sweeps the read address across one padded row and takes back the 3-row column words from the row buffer.
- It slides a 3-column window along the row and streams 3x3 windows to the convolution engine under valid/ready flow control.
- It drives the busy flag that the row buffer samples to decide when the next row may start.

Parameters:
- W, 8 (`IMAGE_WIDTH_DATA): bits per pixel.
- ADDR_BITS, 10: row buffer address width.
- RD_LATENCY, 2: cycles from Rd_Addr issue to matching Row_Data (BRAM read + buffer output register).
- CFIFO_DEPTH, 4: column FIFO entries; must be >= RD_LATENCY+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- Start_Row  in  1  one-cycle pulse: a 3-row band is ready in the row buffer.
- Row_Num_After_Padding  in  ADDR_BITS  padded row width N in columns.
- Rd_Addr  out  ADDR_BITS  column read address to the row buffer.
- Row_Data  in  3*W  column word; [W-1:0]=top row, [2W-1:W]=middle, [3W-1:2W]=bottom.
- Busy  out  1  high while a row is in progress; wired to the row buffer's M_Ready.
- M_Window  out  9*W  window; element k=row*3+col at [k*W +: W]; row 0 = top, col 0 = leftmost/oldest.
- M_Valid  out  1  window valid.
- M_Ready  in  1  downstream accept.
- Row_Done  out  1  one-cycle pulse when the last window of the row is accepted, or when a row with N<3 is retired.

Behaviour:
- Reset values: Rd_Addr=0, Busy=0, M_Valid=0, M_Window=0, Row_Done=0. Reset clears the FSM, all counters, the column FIFO and the shift window.
- Reset mid-row aborts the row; nothing in flight survives.
- N is latched on the cycle Start_Row is sampled in IDLE.
- Start_Row outside IDLE is ignored.
- FSM states:
  - IDLE: on Start_Row go to ISSUE; Busy goes high the next cycle.
  - ISSUE: issue Rd_Addr=0..N-1, one per cycle, but only while fifo_count + inflight < CFIFO_DEPTH. After address N-1 is issued, go to DRAIN.
  - DRAIN: wait until inflight=0, the FIFO is empty and the last window is accepted, then go to DONE.
  - DONE: pulse Row_Done, drop Busy, return to IDLE the same cycle.
- Busy=1 in ISSUE and DRAIN only.
- In-flight tracking: a valid pipe of depth RD_LATENCY tags each issued address. Row_Data is written into the column FIFO exactly RD_LATENCY cycles after issue, unconditionally; the credit rule guarantees space.
- Window shift:
  - The 3-column shift register pops one FIFO word when the FIFO is non-empty and (M_Valid=0 or M_Ready=1).
  - Each pop shifts col0<=col1, col1<=col2, col2<=the new word.
  - A per-row column counter (popped columns) resets at row start.
  - M_Valid is asserted after a pop when the counter is >=3 after increment. The first window appears on the 3rd pop; the row yields N-2 windows.
- Output handshake: M_Window/M_Valid hold steady while M_Valid=1 and M_Ready=0. A simultaneous accept and pop presents the next window the following cycle with no bubble.
- Throughput: with M_Ready held high, 1 window/cycle in steady state. The first window appears RD_LATENCY+3 cycles after the first address is issued.
- N<3 (including 0): N addresses are issued (none if N=0) and the data is discarded. M_Valid is never asserted. Row_Done and Busy drop after the data drains.
- Arithmetic: address and column counters are ADDR_BITS wide; comparisons are against the latched N; no wrap for N<=2^ADDR_BITS-1.

Decomposition:
- Shared package/include: W, the ADDR_BITS default, RD_LATENCY, state encodings (one-hot, matching the row buffer style).
- One sub-module: image_window_col_fifo, a synchronous FIFO of width 3*W and depth CFIFO_DEPTH with count output; reset empties it.

Test Plan:
- N=5, Row_Data word for column c = {8'h20+c, 8'h10+c, 8'h00+c}, M_Ready=1 → windows 0..2; window 0 elements = 00,01,02,10,11,12,20,21,22 (k order). Busy high for exactly the issue+drain span; one Row_Done.
- N=8, M_Ready toggled 1/0 every cycle → exactly 6 windows in order; none duplicated or dropped; M_Window stable while stalled; Rd_Addr pauses when the FIFO credit is exhausted.
- N=2 → 2 addresses issued, M_Valid never asserted, Row_Done pulses, Busy returns to 0.
- Start_Row pulsed again while Busy=1 → ignored; window count is still N-2 for the first row.
- Reset asserted after the 3rd window of an N=16 row → all outputs at reset values the next cycle. A new Start_Row with N=4 yields exactly 2 correct windows, with no stale columns.
- Three back-to-back rows (Start_Row issued the cycle after Busy falls), N=6 → 4 windows each, column counter restarts per row, no window mixes data from two rows.
